// File: rtl/lp_frame_tx_pkg.sv
// Shared definitions for the lightpipe transmit block.
// Contents: word geometry constants, FSM state type, default idle byte.
package lp_pkg;

    localparam int unsigned BITS_PER_WORD  = 256;
    localparam int unsigned BYTES_PER_WORD = 32;

    localparam logic [7:0] IDLE_BYTE_DEFAULT = 8'h00;

    typedef enum logic {
        IDLE,
        RUN
    } state_e;

endpackage

// File: rtl/lp_frame_tx_bit_timer.sv
// Fractional bit divider for the lightpipe transmitter.
// Each bit lasts period_int (clamped to >= 2) clocks plus the carry of an 8-bit
// accumulator that adds period_frac once per bit. The accumulator restarts at
// each word, so a 256-bit word is exactly 256*period_int + period_frac clocks.
// Ports:
//   clk, reset   clock, asynchronous active-low reset
//   run          transmitter is in a word (timer counts)
//   period_int   integer clocks per bit, latched at word_start
//   period_frac  fractional clocks per bit (1/256), latched at word_start
//   word_start   this cycle ends the previous bit and begins bit 0
//   bit_tick     last clock of the current bit
module lp_bit_timer #(
    parameter int unsigned DIVW = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            run,
    input  logic [DIVW-9:0] period_int,
    input  logic [7:0]      period_frac,
    input  logic            word_start,
    output logic            bit_tick
);

    localparam int unsigned PW = DIVW - 8;

    logic [PW-1:0] int_q, int_d, cnt_q, cnt_d, int_src;
    logic [7:0]    frac_q, frac_d, acc_q, acc_d, frac_src, acc_src;
    logic [8:0]    sum;
    logic [PW:0]   len;

    always_comb begin
        // A new word takes fresh period inputs and an empty accumulator.
        int_src  = word_start ? ((period_int < PW'(2)) ? PW'(2) : period_int) : int_q;
        frac_src = word_start ? period_frac : frac_q;
        acc_src  = word_start ? 8'd0 : acc_q;
        sum      = {1'b0, acc_src} + {1'b0, frac_src};
        len      = {1'b0, int_src} + {{PW{1'b0}}, sum[8]};
        bit_tick = run & (cnt_q == '0);

        int_d  = int_q;
        frac_d = frac_q;
        acc_d  = acc_q;
        cnt_d  = cnt_q;
        if (word_start || bit_tick) begin
            int_d  = int_src;
            frac_d = frac_src;
            acc_d  = sum[7:0];
            cnt_d  = PW'(len - 1'b1);
        end else if (run) begin
            cnt_d = cnt_q - 1'b1;
        end else begin
            cnt_d = '0;
            acc_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            int_q  <= '0;
            frac_q <= '0;
            acc_q  <= '0;
            cnt_q  <= '0;
        end else begin
            int_q  <= int_d;
            frac_q <= frac_d;
            acc_q  <= acc_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/lp_frame_tx.sv
// Lightpipe transmitter: word clock (256 bits/word) plus MSB-first serial data.
// Optional build macro LP_TX_PARITY_EN: bit 255 carries even parity over bits
// 0..254 of the same word instead of the last data bit.
// Ports:
//   clk, reset                 clock, asynchronous active-low reset
//   enable                     run request (word always completes)
//   period_int, period_frac    bit period, integer + 1/256 fraction
//   din, din_valid, din_ready  byte input handshake into a one-byte hold register
//   wc                         word clock, high for bits 0..127
//   txd                        serial data
//   bitstrobe                  first clock of every bit
//   underrun                   IDLE_BYTE substituted at a byte boundary
module lp_frame_tx
    import lp_pkg::*;
#(
    parameter int unsigned DIVW      = 16,
    parameter logic [7:0]  IDLE_BYTE = IDLE_BYTE_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            enable,
    input  logic [DIVW-9:0] period_int,
    input  logic [7:0]      period_frac,
    input  logic [7:0]      din,
    input  logic            din_valid,
    output logic            din_ready,
    output logic            wc,
    output logic            txd,
    output logic            bitstrobe,
    output logic            underrun
);

    localparam logic [7:0] LAST_BIT = 8'(BITS_PER_WORD - 1);

    state_e     state_q, state_d;
    logic [7:0] idx_q, idx_d, next_idx;
    logic [7:0] shift_q, shift_d, hold_q, hold_d;
    logic       hold_full_q, hold_full_d;
    logic       strobe_q, strobe_d, underrun_q, underrun_d;
    logic       bit_tick, start, last, running_tick, stop, adv, word_start;
    logic       byte_load, unload, accept, tx_bit;

    lp_bit_timer #(
        .DIVW(DIVW)
    ) u_bit_timer (
        .clk        (clk),
        .reset      (reset),
        .run        (state_q == RUN),
        .period_int (period_int),
        .period_frac(period_frac),
        .word_start (word_start),
        .bit_tick   (bit_tick)
    );

    always_comb begin
        start        = (state_q == IDLE) & enable;
        last         = (idx_q == LAST_BIT);
        running_tick = (state_q == RUN) & bit_tick;
        stop         = running_tick & last & ~enable;
        // adv: next cycle is the first clock of a transmitted bit
        adv          = start | (running_tick & ~stop);
        word_start   = start | (running_tick & last & enable);
        next_idx     = start ? 8'd0 : idx_q + 8'd1;
        byte_load    = adv & (next_idx[2:0] == 3'd0);
        unload       = byte_load & hold_full_q;
        din_ready    = ~hold_full_q | unload;
        accept       = din_valid & din_ready;

        state_d = state_q;
        if (start) begin
            state_d = RUN;
        end else if (stop) begin
            state_d = IDLE;
        end

        idx_d = idx_q;
        if (start || running_tick) begin
            idx_d = next_idx;
        end

        shift_d = shift_q;
        if (byte_load) begin
            shift_d = hold_full_q ? hold_q : IDLE_BYTE;
        end else if (adv) begin
            shift_d = {shift_q[6:0], 1'b0};
        end

        strobe_d   = adv;
        underrun_d = byte_load & ~hold_full_q;

        // Old byte leaves and new byte arrives in the same cycle when both happen.
        hold_d      = accept ? din : hold_q;
        hold_full_d = accept | (hold_full_q & ~unload);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            shift_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            strobe_q    <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            strobe_q    <= strobe_d;
            underrun_q  <= underrun_d;
        end
    end

`ifdef LP_TX_PARITY_EN
    logic par_q, par_d;

    // Running XOR of the bits sent so far in this word; bit 255 is not folded in.
    always_comb begin
        par_d = par_q;
        if (adv) begin
            par_d = ((next_idx == 8'd0) ? 1'b0 : par_q)
                  ^ ((next_idx == LAST_BIT) ? 1'b0 : shift_d[7]);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            par_q <= 1'b0;
        end else begin
            par_q <= par_d;
        end
    end

    assign tx_bit = last ? par_q : shift_q[7];
`else
    assign tx_bit = shift_q[7];
`endif

    assign wc        = (state_q == RUN) & ~idx_q[7];
    assign txd       = (state_q == RUN) & tx_bit;
    assign bitstrobe = strobe_q;
    assign underrun  = underrun_q;

endmodule

// File: tb/tb_lp_frame_tx.sv
`timescale 1ns/1ps
module tb_lp_frame_tx;

    localparam int unsigned DIVW   = 16;
    localparam logic [7:0]  IDLE_B = 8'h00;

    logic       clk = 1'b0;
    logic       reset, enable, din_valid;
    logic [7:0] period_int, period_frac, din;
    logic       din_ready, wc, txd, bitstrobe, underrun;

    lp_frame_tx #(
        .DIVW     (DIVW),
        .IDLE_BYTE(IDLE_B)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .period_int (period_int),
        .period_frac(period_frac),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .wc         (wc),
        .txd        (txd),
        .bitstrobe  (bitstrobe),
        .underrun   (underrun)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Period inputs as seen by the DUT at each rising edge.
    logic [7:0] pi_edge, pf_edge;
    always @(posedge clk) begin
        pi_edge <= period_int;
        pf_edge <= period_frac;
    end

    function automatic int clamp(input int p);
        return (p < 2) ? 2 : p;
    endfunction

    // Bit k of a word lasts pi + (carries gained between k*pf and (k+1)*pf).
    function automatic int bit_len(input int pi, input int pf, input int k);
        return clamp(pi) + ((k + 1) * pf) / 256 - (k * pf) / 256;
    endfunction

    // Scoreboard: accepted bytes with the edge on which they entered the DUT.
    logic [7:0] q_val[$];
    int         q_edge[$];

    int         m_idx = 255;
    int         w_pi = 4, w_pf = 0;
    int         last_strobe = 0, word_start_cyc = 0, word_count = 0;
    bit         restart = 1'b1;
    bit         acc_flag = 1'b0;
    bit         par_acc = 1'b0;
    logic [7:0] cur_byte = 8'h00;

    always @(negedge clk) begin : monitor
        int k, exp_bit, exp_und;
        if (reset) begin
            if (bitstrobe) begin
                k = (m_idx + 1) % 256;
                if (!restart) begin
                    check("bit_len", cyc - last_strobe, bit_len(w_pi, w_pf, m_idx));
                    if (k == 0) begin
                        check("word_len", cyc - word_start_cyc, 256 * clamp(w_pi) + w_pf);
                    end
                end
                restart = 1'b0;
                if (k == 0) begin
                    w_pi           = int'(pi_edge);
                    w_pf           = int'(pf_edge);
                    word_start_cyc = cyc;
                    par_acc        = 1'b0;
                    word_count++;
                end
                last_strobe = cyc;
                m_idx       = k;
                exp_und     = 0;
                if (k % 8 == 0) begin
                    if (q_val.size() > 0 && q_edge[0] < cyc) begin
                        cur_byte = q_val.pop_front();
                        void'(q_edge.pop_front());
                    end else begin
                        cur_byte = IDLE_B;
                        exp_und  = 1;
                    end
                end
                exp_bit = int'(cur_byte[7 - (k % 8)]);
`ifdef LP_TX_PARITY_EN
                if (k == 255) exp_bit = int'(par_acc);
`endif
                if (k != 255) par_acc = par_acc ^ exp_bit[0];
                check("wc", int'(wc), (k < 128) ? 1 : 0);
                check("txd", int'(txd), exp_bit);
                check("underrun", int'(underrun), exp_und);
            end else begin
                check("underrun_no_strobe", int'(underrun), 0);
            end
        end
        acc_flag = reset && din_valid && din_ready;
        if (acc_flag) begin
            q_val.push_back(din);
            q_edge.push_back(cyc + 1);
        end
    end

    // Input driver: 0 = never valid, 1 = always valid, 2 = random valid.
    int         valid_mode = 1;
    logic [7:0] stim[$];

    initial begin
        din       = 8'h00;
        din_valid = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (acc_flag && stim.size() > 0) void'(stim.pop_front());
            if (stim.size() == 0) stim.push_back(8'($urandom));
            din       = stim[0];
            din_valid = (valid_mode == 1) || (valid_mode == 2 && ($urandom % 4) != 0);
        end
    end

    task automatic wait_idx(input int k, input int budget);
        int n = 0;
        while (m_idx != k && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (m_idx != k) check("timeout_wait_idx", m_idx, k);
    endtask

    task automatic wait_words(input int target, input int budget);
        int n = 0;
        while (word_count < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (word_count < target) check("timeout_wait_words", word_count, target);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_wc"}, int'(wc), 0);
        check({tag, "_txd"}, int'(txd), 0);
        check({tag, "_bitstrobe"}, int'(bitstrobe), 0);
        check({tag, "_underrun"}, int'(underrun), 0);
        check({tag, "_din_ready"}, int'(din_ready), 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b0;
        enable      = 1'b0;
        period_int  = 8'd4;
        period_frac = 8'd0;
        valid_mode  = 1;
        stim.push_back(8'hA5);
        stim.push_back(8'h3C);

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(posedge clk);
        #1 reset = 1'b1;

        // Hold register fills with 0xA5 while idle; 0x3C then waits.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("idle_hold_full_ready", int'(din_ready), 0);
        check("idle_wc", int'(wc), 0);

        @(posedge clk);
        #1 enable = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("start_bitstrobe", int'(bitstrobe), 1);
        check("start_wc", int'(wc), 1);
        check("start_txd", int'(txd), 1);

        // 4/128 takes effect at word 2; mid-word change back to 0 hits word 4.
        wait_idx(150, 2000);
        period_frac = 8'd128;
        wait_words(3, 5000);
        wait_idx(100, 2000);
        period_frac = 8'd0;
        wait_words(5, 5000);

        // No data for a word: idle bytes with underruns.
        valid_mode = 0;
        wait_words(6, 5000);

        // Random data gaps and periods (includes clamped values 0 and 1).
        valid_mode = 2;
        for (int i = 0; i < 18; i++) begin
            period_int  = 8'($urandom_range(0, 6));
            period_frac = 8'($urandom);
            repeat (200) @(posedge clk);
        end
        period_int  = 8'd4;
        period_frac = 8'd64;

        // Enable drops mid-word: the word still completes, then the line idles.
        wait_words(word_count + 1, 5000);
        wait_idx(60, 3000);
        #1 enable = 1'b0;
        wait_idx(255, 3000);
        repeat (12) @(posedge clk);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("stopped_bitstrobe", int'(bitstrobe), 0);
            check("stopped_wc", int'(wc), 0);
            check("stopped_txd", int'(txd), 0);
        end

        // Restart; held byte must be the first one out.
        @(posedge clk);
        #1;
        restart = 1'b1;
        enable  = 1'b1;
        valid_mode = 1;
        wait_words(word_count + 2, 6000);

        // Asynchronous reset in the middle of bit 100.
        wait_idx(100, 3000);
        #3 reset = 1'b0;
        #1;
        check_reset_outputs("midword_reset");
        q_val.delete();
        q_edge.delete();
        m_idx   = 255;
        restart = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("restart_bitstrobe", int'(bitstrobe), 1);
        check("restart_wc", int'(wc), 1);
        wait_words(word_count + 2, 6000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/lp_frame_tx.md
Name: lp_frame_tx

Overview:
- Transmit end of the lightpipe word-clock/bit link.
- Generates a word clock `wc` of exactly 256 bit periods, using a fractional bit period.
- Serializes a byte stream MSB-first onto `txd`, with a strobe on every bit boundary.
- Output timing matches what the receive-side dpll expects: word length = 256*period_int + period_frac clocks, rising `wc` at bit 0.

Parameters:
- DIVW, 16: width of the word-length field. Word length in clocks fits in DIVW+1 bits.
- IDLE_BYTE, 8'h00: byte transmitted when no input data is available at a byte boundary.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- enable  input  1  run request; level-sensitive
- period_int  input  DIVW-8  integer clocks per bit; values below 2 are clamped to 2
- period_frac  input  8  fractional clocks per bit, in 1/256 units
- din  input  8  transmit byte
- din_valid  input  1  `din` holds a byte
- din_ready  output  1  block accepts `din` this cycle
- wc  output  1  word clock
- txd  output  1  serial data
- bitstrobe  output  1  one-clock pulse at each bit start
- underrun  output  1  one-clock pulse when IDLE_BYTE is substituted

Behaviour:
- Reset (asynchronous, reset=0): all of the following are forced.
  - State IDLE.
  - wc=0, txd=0, bitstrobe=0, underrun=0.
  - Hold register empty, so din_ready=1.
  - Bit index 0; timers 0.
- States: IDLE and RUN.
  - IDLE -> RUN on enable=1.
  - RUN -> IDLE only at a word boundary (end of bit 255) with enable=0. A word is never truncated.
  - In IDLE: wc=0, txd=0, bitstrobe=0. The input handshake stays live and fills the hold register.
- Start latency: enable sampled high in cycle t gives, in cycle t+1, all of the following.
  - RUN state, bit index 0.
  - bitstrobe=1, wc rising, txd = MSB of the first byte.
- Period latching: period_int and period_frac are latched only at bit 0. Changes mid-word take effect at the next word.
- Bit timer: a fractional divider.
  - An 8-bit accumulator adds period_frac at each bit boundary.
  - Bit length = period_int + carry out of the accumulator.
  - The accumulator resets to 0 at each bit 0, so the word length is exact: 256*period_int + period_frac.
- bitstrobe is high for the first clock of each bit.
- wc = 1 for bits 0..127 and 0 for bits 128..255. Exactly one rising edge per word, at bit 0.
- Byte pipeline:
  - A one-byte hold register feeds an 8-bit shift register.
  - At every bit where index[2:0]==0, the shift register loads the hold byte if one is present. Otherwise it loads IDLE_BYTE and pulses underrun for one clock.
  - txd = shift[7]; the shift register shifts at each other bit boundary.
- Handshake:
  - din_ready = hold empty OR the hold register is being unloaded this cycle.
  - A transfer occurs when din_valid & din_ready.
  - Load and accept in the same cycle is legal: the old byte goes out and the new byte is held. No byte is lost or duplicated.
- Wrap-around: bit index 255 -> 0 stays in RUN when enable=1, with no gap clocks between words.
- enable dropping mid-word: the word completes, including byte fetches. The hold register keeps any unsent byte.

Optional Feature:
- Macro: LP_TX_PARITY_EN.
- When defined: bit 255 (LSB of byte 31) is replaced by even parity over bits 0..254 of the same word. The accumulator clears at bit 0.
- When undefined: all 256 bits are data.

Decomposition:
- Package lp_pkg holds:
  - constant BITS_PER_WORD=256 and BYTES_PER_WORD=32;
  - the state enum {IDLE, RUN};
  - the IDLE_BYTE default.
- One sub-module, lp_bit_timer: the integer+fraction bit divider.
  - Inputs: clk, reset, run, period_int, period_frac, word_start.
  - Output: bit_tick.
- The top level owns the FSM, bit index, wc, byte pipeline and optional parity.

Test Plan:
- period_int=4, period_frac=0, enable=1, continuous valid data:
  - wc rises every 1024 clocks and is high for 512;
  - bitstrobe every 4 clocks;
  - first rising wc one clock after enable.
- period_int=4, period_frac=128:
  - bit lengths alternate 4/5;
  - word length exactly 1152 clocks every word;
  - a mid-word change to period_frac=0 gives 1152 for the current word, then 1024.
- din stream 0xA5, 0x3C, ...:
  - txd reads 1,0,1,0,0,1,0,1, then 0,0,1,1,1,1,0,0 at successive bitstrobes;
  - din_ready never drops the stream.
- din_valid=0 throughout: txd constant 0, with 32 underrun pulses per word, each aligned to an index[2:0]==0 bitstrobe.
- Reset asserted at bit 100:
  - all outputs are 0 in the same cycle;
  - after release with enable=1, a word restarts at bit 0 with a fresh rising wc.
- Loopback to the receive-side dpll with period_int=8: its locked output goes 1 by the second wc edge and stays 1. With LP_TX_PARITY_EN defined, the recomputed parity matches on every word.
